// File: rtl/tl_pkg.sv
// Shared light codes, state encoding and timing defaults
// for the two-road traffic-light phase scheduler.
package tl_pkg;

  localparam logic [1:0] LC_GREEN  = 2'b00;
  localparam logic [1:0] LC_YELLOW = 2'b01;
  localparam logic [1:0] LC_RED    = 2'b10;
  localparam logic [1:0] LC_LEFT   = 2'b11;

  localparam int unsigned MIN_GREEN_DEF = 4;
  localparam int unsigned MAX_GREEN_DEF = 8;
  localparam int unsigned YELLOW_T_DEF  = 2;

  typedef enum logic [2:0] {
    A_GO   = 3'd0,
    A_YEL  = 3'd1,
    A_LEFT = 3'd2,
    A_LYEL = 3'd3,
    B_GO   = 3'd4,
    B_YEL  = 3'd5,
    B_LEFT = 3'd6,
    B_LYEL = 3'd7
  } state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: 4-bit up-counter, saturates at 15.
// Ports: clk, clear (sync, wins), enable, count.
module tl_phase_timer (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= 4'd0;
    end else if (enable && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/tl_phase_sched.sv
// Moore phase scheduler for two roads with left turns.
// Ports: clk, reset, Ta/Tb/Tal/Tbl sensors, La/Lb lights, phase.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int unsigned MIN_GREEN = MIN_GREEN_DEF,
  parameter int unsigned MAX_GREEN = MAX_GREEN_DEF,
  parameter int unsigned YELLOW_T  = YELLOW_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Tal,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] phase
);

  localparam logic [3:0] MIN_M1 = 4'(MIN_GREEN - 1);
  localparam logic [3:0] MAX_M1 = 4'(MAX_GREEN - 1);
  localparam logic [3:0] YEL_M1 = 4'(YELLOW_T - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] timer;
  logic       timer_clr;

  logic req_a, req_al, req_b, req_bl;
  logic min_ok, max_hit, yel_done;
  logic enter_a, enter_al, enter_b, enter_bl;

  assign min_ok   = (timer >= MIN_M1);
  assign max_hit  = (timer >= MAX_M1);
  assign yel_done = (timer == YEL_M1);

  // Timer restarts on the edge that changes state.
  assign timer_clr = reset || (state_nxt != state);

  tl_phase_timer u_timer (
    .clk    (clk),
    .clear  (timer_clr),
    .enable (1'b1),
    .count  (timer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= A_GO;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      A_GO: begin
        if (min_ok && (req_al || req_b || req_bl)
            && (!Ta || max_hit))
          state_nxt = A_YEL;
      end
      A_YEL: begin
        if (yel_done)
          state_nxt = req_al ? A_LEFT : B_GO;
      end
      A_LEFT: begin
        if (min_ok && (!Tal || max_hit))
          state_nxt = A_LYEL;
      end
      A_LYEL: begin
        if (yel_done)
          state_nxt = B_GO;
      end
      B_GO: begin
        if (min_ok && (req_bl || req_a || req_al)
            && (!Tb || max_hit))
          state_nxt = B_YEL;
      end
      B_YEL: begin
        if (yel_done)
          state_nxt = req_bl ? B_LEFT : A_GO;
      end
      B_LEFT: begin
        if (min_ok && (!Tbl || max_hit))
          state_nxt = B_LYEL;
      end
      B_LYEL: begin
        if (yel_done)
          state_nxt = A_GO;
      end
    endcase
  end

  always_comb begin
    phase = state;
    La    = LC_RED;
    Lb    = LC_RED;
    unique case (state)
      A_GO:   La = LC_GREEN;
      A_YEL:  La = LC_YELLOW;
      A_LEFT: La = LC_LEFT;
      A_LYEL: La = LC_YELLOW;
      B_GO:   Lb = LC_GREEN;
      B_YEL:  Lb = LC_YELLOW;
      B_LEFT: Lb = LC_LEFT;
      B_LYEL: Lb = LC_YELLOW;
    endcase
  end

  assign enter_a  = (state_nxt == A_GO)   && (state != A_GO);
  assign enter_al = (state_nxt == A_LEFT) && (state != A_LEFT);
  assign enter_b  = (state_nxt == B_GO)   && (state != B_GO);
  assign enter_bl = (state_nxt == B_LEFT) && (state != B_LEFT);

  // Sticky requests; being served clears them even if the
  // sensor is still asserted on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_a  <= 1'b0;
      req_al <= 1'b0;
      req_b  <= 1'b0;
      req_bl <= 1'b0;
    end else begin
      req_a  <= enter_a  ? 1'b0
              : (req_a  || (Ta  && (state != A_GO)));
      req_al <= enter_al ? 1'b0
              : (req_al || (Tal && (state != A_LEFT)));
      req_b  <= enter_b  ? 1'b0
              : (req_b  || (Tb  && (state != B_GO)));
      req_bl <= enter_bl ? 1'b0
              : (req_bl || (Tbl && (state != B_LEFT)));
    end
  end

endmodule
